wb_pipe: RTL and testbench
==========================

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- DATA_W, 20: width of result and write-back data.
- INS_W, 20: instruction word width.
- RA_W, 4: register address width.
- RT_LSB, 4: LSB of the R-type destination field in ins.
- IT_LSB, 8: LSB of the non-R-type destination field in ins.
- LINK_REG, 15: destination used by jal.

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: MEM-stage instruction valid.
- stall, in, 1: hold the WB stage.
- flush, in, 1: discard the incoming instruction.
- rtype, in, 1: R-type instruction.
- lw, in, 1: load instruction.
- jal, in, 1: jump-and-link instruction.
- ins, in, INS_W: instruction word.
- alu_res, in, DATA_W: ALU result.
- mem_res, in, DATA_W: load data.
- pc_link, in, DATA_W: return address.
- q_addr_a, in, RA_W: forwarding query address, port A.
- q_addr_b, in, RA_W: forwarding query address, port B.
- wb_we, out, 1: register-file write enable.
- wb_dest, out, RA_W: write address.
- wb_data, out, DATA_W: write data.
- wb_valid, out, 1: WB stage holds a valid instruction.
- fwd_hit_a, out, 1: forwarding hit on port A.
- fwd_data_a, out, DATA_W: forwarded data for port A.
- fwd_hit_b, out, 1: forwarding hit on port B.
- fwd_data_b, out, DATA_W: forwarded data for port B.

REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL compute the destination as follows: jal gives LINK_REG; else rtype gives ins[RT_LSB+RA_W-1:RT_LSB]; else ins[IT_LSB+RA_W-1:IT_LSB].
REQ-005 SHALL select data with priority jal > lw > ALU: pc_link, then mem_res, otherwise alu_res.
REQ-006 SHALL set the write intent to in_valid & (rtype | lw | jal) & (dest != 0); writes to register 0 are suppressed.
REQ-007 SHALL capture dest, data, intent and in_valid into the WB register on each rising edge where stall=0; the latency is 1 cycle.
REQ-008 SHALL, when flush=1, capture a bubble (valid=0, intent=0); flush has priority over stall.
REQ-009 SHALL, when stall=1 and flush=0, hold the WB register unchanged.
REQ-010 SHALL assert wb_we = intent & ~committed, where committed is a flag set on the edge after wb_we=1 and cleared whenever the WB register loads new contents.
- Each instruction therefore writes exactly once, even if stalled for many cycles.
REQ-011 SHALL drive wb_dest and wb_data from the WB register in all cycles; wb_valid SHALL mirror the WB valid bit.
REQ-012 SHALL hold a DONE register (dest, data, valid), loaded on every edge where wb_we=1; otherwise DONE is held.
REQ-013 SHALL assert fwd_hit_x when q_addr_x != 0 and either of the following holds:
- the WB register has intent=1 and a matching dest, or
- DONE is valid with a matching dest.
REQ-014 SHALL give WB priority over DONE when both match; fwd_data_x SHALL be the WB data in that case and the DONE data otherwise.
REQ-015 SHALL drive fwd_data_x to 0 when fwd_hit_x=0.
REQ-016 SHALL keep forwarding combinational on the registered state plus q_addr only, with no path from the MEM-stage inputs.
REQ-017 SHALL treat the combination lw & jal by REQ-005 priority; the combination rtype & jal SHALL take LINK_REG as destination.

Reset
REQ-018 SHALL, on any edge with rst=1 and regardless of stall or flush, clear the WB register, the committed flag and the DONE register.
- All outputs read 0 in the following cycle.
REQ-019 SHALL abandon any in-flight or stalled instruction on a mid-operation reset; no write is issued for it afterwards.

Verification
REQ-020 SHALL cover an R-type capture:
- Stimulus: rtype=1, ins=20'h00350, alu_res=20'h0ABCD, in_valid=1.
- Required: next cycle wb_we=1, wb_dest=5, wb_data=20'h0ABCD.
REQ-021 SHALL cover load and jal:
- Load stimulus: lw=1, ins=20'h00700, mem_res=20'h12345.
- Load required: wb_dest=7, wb_data=20'h12345.
- jal stimulus: jal=1, pc_link=20'h00040.
- jal required: wb_dest=15, wb_data=20'h00040.
REQ-022 SHALL cover a register-0 write:
- Stimulus: rtype=1, ins=20'h00000.
- Required: wb_valid=1, wb_we=0; fwd_hit=0 for q_addr=0.
REQ-023 SHALL cover stall across a write:
- Stimulus: load R3, then stall=1 for 3 cycles.
- Required: wb_we=1 for exactly 1 cycle; wb_dest=3 is held; DONE holds R3.
REQ-024 SHALL cover forwarding priority:
- Stimulus: write R2=20'h00011, then R2=20'h00022 back-to-back; query q_addr_a=2 while the second write is in WB.
- Required: fwd_hit_a=1, fwd_data_a=20'h00022.
REQ-025 SHALL cover flush plus stall and a mid-stall reset:
- Flush stimulus: flush=1 and stall=1 together.
- Flush required: next cycle wb_valid=0, wb_we=0.
- Reset stimulus: rst=1 while stalled.
- Reset required: all outputs 0; no write after release.

Source files
------------

// File: rtl/wb_pipe_if.sv
// wb_pipe_if -- bundles the MEM-stage instruction inputs, the forwarding
// query addresses and every write-back/forwarding output of wb_pipe.
//   master : drives the MEM-stage inputs and queries (pipeline side / bench)
//   slave  : the wb_pipe write-back stage itself
// Signals:
//   in_valid, stall, flush, rtype, lw, jal, ins, alu_res, mem_res, pc_link,
//   q_addr_a, q_addr_b                                  (master -> slave)
//   wb_we, wb_dest, wb_data, wb_valid,
//   fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b        (slave -> master)
interface wb_pipe_if #(
  parameter int DATA_W = 20,
  parameter int INS_W  = 20,
  parameter int RA_W   = 4
);
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic              rtype;
  logic              lw;
  logic              jal;
  logic [INS_W-1:0]  ins;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mem_res;
  logic [DATA_W-1:0] pc_link;
  logic [RA_W-1:0]   q_addr_a;
  logic [RA_W-1:0]   q_addr_b;

  logic              wb_we;
  logic [RA_W-1:0]   wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              fwd_hit_a;
  logic [DATA_W-1:0] fwd_data_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_b;

  modport master (
    output in_valid, stall, flush, rtype, lw, jal, ins,
           alu_res, mem_res, pc_link, q_addr_a, q_addr_b,
    input  wb_we, wb_dest, wb_data, wb_valid,
           fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b
  );

  modport slave (
    input  in_valid, stall, flush, rtype, lw, jal, ins,
           alu_res, mem_res, pc_link, q_addr_a, q_addr_b,
    output wb_we, wb_dest, wb_data, wb_valid,
           fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b
  );
endinterface

// File: rtl/wb_pipe.sv
// wb_pipe -- write-back stage of a simple in-order pipeline.
// Captures the MEM-stage instruction (destination, data, write intent) into
// the WB register, issues exactly one register-file write per instruction even
// across long stalls, and keeps the last committed write in a DONE register so
// two forwarding ports can be served from WB (newest) or DONE (older).
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : wb_pipe_if.slave -- MEM-stage inputs, forwarding queries,
//          write-back and forwarding outputs
module wb_pipe #(
  parameter int DATA_W   = 20,
  parameter int INS_W    = 20,
  parameter int RA_W     = 4,
  parameter int RT_LSB   = 4,
  parameter int IT_LSB   = 8,
  parameter int LINK_REG = 15
) (
  input logic       clk,
  input logic       rst,
  wb_pipe_if.slave  bus
);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_t;

  // MEM-stage decode
  logic [RA_W-1:0]   mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              mem_intent;

  // WB register
  logic [RA_W-1:0]   wb_dest_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_intent_q;
  logic              wb_valid_q;
  logic              committed_q;

  // DONE register: last write actually issued to the register file
  logic [RA_W-1:0]   done_dest_q;
  logic [DATA_W-1:0] done_data_q;
  logic              done_valid_q;

  logic              wb_we;
  fwd_t              fwd_a;
  fwd_t              fwd_b;

  // jal wins over rtype for the destination; jal wins over lw for the data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    mem_dest = bus.ins[IT_LSB +: RA_W];
    mem_data = bus.alu_res;
    if (bus.jal) begin
      mem_dest = RA_W'(LINK_REG);
      mem_data = bus.pc_link;
    end else begin
      if (bus.rtype) mem_dest = bus.ins[RT_LSB +: RA_W];
      if (bus.lw)    mem_data = bus.mem_res;
    end
    mem_intent = bus.in_valid & (bus.rtype | bus.lw | bus.jal) & (mem_dest != '0);
  end

  // The write fires once: committed is set after the write cycle and only
  // cleared when the WB register takes new contents.
  assign wb_we = wb_intent_q & ~committed_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
      wb_intent_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      committed_q  <= 1'b0;
      done_dest_q  <= '0;
      done_data_q  <= '0;
      done_valid_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        // Bubble; flush overrides stall.
        wb_dest_q   <= '0;
        wb_data_q   <= '0;
        wb_intent_q <= 1'b0;
        wb_valid_q  <= 1'b0;
        committed_q <= 1'b0;
      end else if (!bus.stall) begin
        wb_dest_q   <= mem_dest;
        wb_data_q   <= mem_data;
        wb_intent_q <= mem_intent;
        wb_valid_q  <= bus.in_valid;
        committed_q <= 1'b0;
      end else if (wb_we) begin
        committed_q <= 1'b1;
      end

      if (wb_we) begin
        done_dest_q  <= wb_dest_q;
        done_data_q  <= wb_data_q;
        done_valid_q <= 1'b1;
      end
    end
  end

  // Forwarding looks only at registered state; WB is newer than DONE.
  function automatic fwd_t lookup(input logic [RA_W-1:0] addr);
    fwd_t r;
    r = '0;
    if (addr != '0) begin
      if (wb_intent_q && wb_dest_q == addr) begin
        r.hit  = 1'b1;
        r.data = wb_data_q;
      end else if (done_valid_q && done_dest_q == addr) begin
        r.hit  = 1'b1;
        r.data = done_data_q;
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd_a = lookup(bus.q_addr_a);
    fwd_b = lookup(bus.q_addr_b);
  end

  assign bus.wb_we      = wb_we;
  assign bus.wb_dest    = wb_dest_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.fwd_hit_a  = fwd_a.hit;
  assign bus.fwd_data_a = fwd_a.data;
  assign bus.fwd_hit_b  = fwd_b.hit;
  assign bus.fwd_data_b = fwd_b.data;

endmodule

// File: tb/tb_wb_pipe.sv
// tb_wb_pipe -- directed self-checking bench for wb_pipe.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, well away from the next edge.
module tb_wb_pipe;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  wb_pipe_if #(.DATA_W(20), .INS_W(20), .RA_W(4)) bus ();

  wb_pipe #(
    .DATA_W(20), .INS_W(20), .RA_W(4),
    .RT_LSB(4), .IT_LSB(8), .LINK_REG(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.rtype    = 1'b0;
    bus.lw       = 1'b0;
    bus.jal      = 1'b0;
    bus.ins      = '0;
    bus.alu_res  = '0;
    bus.mem_res  = '0;
    bus.pc_link  = '0;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [3:0] dest,
                          input logic [19:0] data, input logic valid);
    check({tag, ".we"},    32'(bus.wb_we),    32'(we));
    check({tag, ".dest"},  32'(bus.wb_dest),  32'(dest));
    check({tag, ".data"},  32'(bus.wb_data),  32'(data));
    check({tag, ".valid"}, 32'(bus.wb_valid), 32'(valid));
  endtask

  task automatic check_fwd_a(input string tag, input logic hit, input logic [19:0] data);
    check({tag, ".hit_a"},  32'(bus.fwd_hit_a),  32'(hit));
    check({tag, ".data_a"}, 32'(bus.fwd_data_a), 32'(data));
  endtask

  task automatic check_fwd_b(input string tag, input logic hit, input logic [19:0] data);
    check({tag, ".hit_b"},  32'(bus.fwd_hit_b),  32'(hit));
    check({tag, ".data_b"}, 32'(bus.fwd_data_b), 32'(data));
  endtask

  int we_cnt;

  initial begin
    idle_inputs();
    bus.q_addr_a = 4'd1;
    bus.q_addr_b = 4'd15;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_wb("reset", 1'b0, 4'd0, 20'h0, 1'b0);
    check_fwd_a("reset", 1'b0, 20'h0);
    check_fwd_b("reset", 1'b0, 20'h0);

    // R-type capture: dest from ins[7:4] = 5
    bus.in_valid = 1'b1;
    bus.rtype    = 1'b1;
    bus.ins      = 20'h00350;
    bus.alu_res  = 20'h0ABCD;
    bus.q_addr_a = 4'd5;
    step();
    check_wb("rtype", 1'b1, 4'd5, 20'h0ABCD, 1'b1);
    check_fwd_a("rtype_fwd_wb", 1'b1, 20'h0ABCD);

    // Load: dest from ins[11:8] = 7, data from mem_res
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.lw       = 1'b1;
    bus.ins      = 20'h00700;
    bus.mem_res  = 20'h12345;
    bus.alu_res  = 20'h55555;
    bus.q_addr_b = 4'd5;
    step();
    check_wb("load", 1'b1, 4'd7, 20'h12345, 1'b1);
    check_fwd_b("load_fwd_done", 1'b1, 20'h0ABCD);

    // jal together with lw and rtype: link register and pc_link win
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.jal      = 1'b1;
    bus.lw       = 1'b1;
    bus.rtype    = 1'b1;
    bus.ins      = 20'h00350;
    bus.pc_link  = 20'h00040;
    bus.mem_res  = 20'h12345;
    step();
    check_wb("jal", 1'b1, 4'd15, 20'h00040, 1'b1);

    // Register-0 write is suppressed; q_addr 0 never hits
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.rtype    = 1'b1;
    bus.ins      = 20'h00000;
    bus.alu_res  = 20'h99999;
    bus.q_addr_a = 4'd0;
    bus.q_addr_b = 4'd15;
    step();
    check_wb("r0", 1'b0, 4'd0, 20'h99999, 1'b1);
    check_fwd_a("r0_q0", 1'b0, 20'h0);
    check_fwd_b("r0_done_r15", 1'b1, 20'h00040);

    // Load R3, then stall 3 cycles while MEM offers another instruction
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.lw       = 1'b1;
    bus.ins      = 20'h00300;
    bus.mem_res  = 20'h33333;
    bus.q_addr_a = 4'd3;
    step();
    we_cnt = 0;
    if (bus.wb_we) we_cnt++;
    check_wb("stall_load", 1'b1, 4'd3, 20'h33333, 1'b1);
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.rtype    = 1'b1;
    bus.ins      = 20'h00090;
    bus.alu_res  = 20'h77777;
    bus.stall    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.wb_we) we_cnt++;
      check_wb($sformatf("stall%0d", i), 1'b0, 4'd3, 20'h33333, 1'b1);
      check_fwd_a($sformatf("stall%0d_fwd", i), 1'b1, 20'h33333);
    end
    check("stall_we_count", 32'(we_cnt), 32'd1);
    // DONE must hold R3 on its own once WB moves on to a bubble
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check_fwd_a("stall_done_r3", 1'b1, 20'h33333);

    // Back-to-back R2 writes: WB (newer) beats DONE
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.rtype    = 1'b1;
    bus.ins      = 20'h00020;
    bus.alu_res  = 20'h00011;
    step();
    bus.alu_res  = 20'h00022;
    step();
    bus.q_addr_a = 4'd2;
    bus.q_addr_b = 4'd3;
    #1;
    check_wb("r2_second", 1'b1, 4'd2, 20'h00022, 1'b1);
    check_fwd_a("fwd_prio", 1'b1, 20'h00022);
    check_fwd_b("fwd_r3_gone", 1'b0, 20'h0);

    // flush + stall together: bubble
    bus.ins      = 20'h00040;
    bus.alu_res  = 20'h44444;
    bus.flush    = 1'b1;
    bus.stall    = 1'b1;
    step();
    check("flush.valid", 32'(bus.wb_valid), 32'd0);
    check("flush.we",    32'(bus.wb_we),    32'd0);
    check_fwd_a("flush_fwd_done", 1'b1, 20'h00022);

    // Load R6, then reset while stalled
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.lw       = 1'b1;
    bus.ins      = 20'h00600;
    bus.mem_res  = 20'h66666;
    bus.q_addr_a = 4'd6;
    bus.q_addr_b = 4'd2;
    step();
    check_wb("r6_load", 1'b1, 4'd6, 20'h66666, 1'b1);
    bus.stall = 1'b1;
    rst       = 1'b1;
    step();
    check_wb("mid_rst", 1'b0, 4'd0, 20'h0, 1'b0);
    check_fwd_a("mid_rst", 1'b0, 20'h0);
    check_fwd_b("mid_rst", 1'b0, 20'h0);
    rst = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.wb_we) we_cnt++;
      check_wb($sformatf("post_rst_stall%0d", i), 1'b0, 4'd0, 20'h0, 1'b0);
    end
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    if (bus.wb_we) we_cnt++;
    check("post_rst_we_count", 32'(we_cnt), 32'd0);
    check_fwd_a("post_rst_fwd", 1'b0, 20'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
